// File: rtl/lalu_arbiter.sv
// lalu_arbiter
//   Round-robin arbiter and operation sequencer in front of a single LALU.
//   Two requesters offer {op, a, b} over valid/ready. The winner's operation
//   is latched and issued to the ALU. After ALU_LATENCY cycles the result is
//   captured and returned with the owner's ID over a valid/ready response
//   channel. Only one operation is in flight at a time.
//
// Ports
//   fpgaGlobalClock      clock, rising edge
//   rst_0                asynchronous active-high reset
//   reqN_valid/ready     request handshake (ready is combinational, IDLE only)
//   reqN_op/a/b          request payload
//   alu_issue            one-cycle start pulse to the ALU
//   alu_op/a/b           operation held for the ALU
//   alu_result           ALU output, sampled ALU_LATENCY cycles after issue
//   rsp_valid/ready      response handshake
//   rsp_id/result        owner and captured result
//   busy                 high whenever the sequencer is not idle
module lalu_arbiter #(
  parameter int WIDTH       = 16,
  parameter int OPW         = 4,
  parameter int ALU_LATENCY = 2    // 1..15
) (
  input  logic             fpgaGlobalClock,
  input  logic             rst_0,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_issue,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic gnt0, gnt1;

  // Grant decision. Ready is gated by reset so nothing is offered while
  // rst_0 is high. On a tie the requester that did not win last time goes.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && !rst_0) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    case (state_q)
      S_IDLE: begin
        // A grant implies the matching valid is high, so grant == accept.
        if (gnt0 || gnt1) begin
          state_d      = S_ISSUE;
          op_d         = gnt1 ? req1_op : req0_op;
          a_d          = gnt1 ? req1_a  : req0_a;
          b_d          = gnt1 ? req1_b  : req0_b;
          owner_d      = gnt1;
          last_grant_d = gnt1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = LAT;
      end
      S_WAIT: begin
        // The last WAIT cycle is the one where alu_result is valid.
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          result_d = alu_result;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fpgaGlobalClock or posedge rst_0) begin
    if (rst_0) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  assign alu_issue  = (state_q == S_ISSUE);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = owner_q;
  assign rsp_result = result_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lalu_arbiter.sv
`timescale 1ns/1ps
module tb_lalu_arbiter;

  localparam int W = 16;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance, ALU_LATENCY = 2
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = 0, req1_op = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic         alu_issue, rsp_valid, rsp_id, busy;
  logic         rsp_ready = 1;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;

  lalu_arbiter #(.WIDTH(W), .OPW(4), .ALU_LATENCY(L)) dut (
    .fpgaGlobalClock(clk), .rst_0(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_issue(alu_issue), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy));

  // Second instance, ALU_LATENCY = 1
  logic         u1_req0_valid = 0, u1_req1_valid = 0;
  logic         u1_req0_ready, u1_req1_ready;
  logic [3:0]   u1_req1_op = 0;
  logic [W-1:0] u1_req1_a = 0, u1_req1_b = 0;
  logic         u1_alu_issue, u1_rsp_valid, u1_rsp_id, u1_busy;
  logic         u1_rsp_ready = 1;
  logic [3:0]   u1_alu_op;
  logic [W-1:0] u1_alu_a, u1_alu_b, u1_alu_result, u1_rsp_result;

  lalu_arbiter #(.WIDTH(W), .OPW(4), .ALU_LATENCY(1)) u1 (
    .fpgaGlobalClock(clk), .rst_0(rst),
    .req0_valid(u1_req0_valid), .req0_ready(u1_req0_ready), .req0_op(4'h0),
    .req0_a(16'h0000), .req0_b(16'h0000),
    .req1_valid(u1_req1_valid), .req1_ready(u1_req1_ready), .req1_op(u1_req1_op),
    .req1_a(u1_req1_a), .req1_b(u1_req1_b),
    .alu_issue(u1_alu_issue), .alu_op(u1_alu_op), .alu_a(u1_alu_a), .alu_b(u1_alu_b),
    .alu_result(u1_alu_result),
    .rsp_valid(u1_rsp_valid), .rsp_ready(u1_rsp_ready), .rsp_id(u1_rsp_id),
    .rsp_result(u1_rsp_result), .busy(u1_busy));

  // ALU models: a+b is visible only in the single cycle it is due, otherwise
  // a poison value, so sampling at the wrong cycle shows up in rsp_result.
  logic [W-1:0] alu_val = 0, u1_alu_val = 0;
  int alu_cnt = 0, u1_alu_cnt = 0;
  always @(posedge clk) begin
    if (alu_issue) begin alu_val <= alu_a + alu_b; alu_cnt <= L; end
    else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
    if (u1_alu_issue) begin u1_alu_val <= u1_alu_a + u1_alu_b; u1_alu_cnt <= 1; end
    else if (u1_alu_cnt > 0) u1_alu_cnt <= u1_alu_cnt - 1;
  end
  assign alu_result    = (alu_cnt == 1)    ? alu_val    : 16'hBAD0;
  assign u1_alu_result = (u1_alu_cnt == 1) ? u1_alu_val : 16'hBAD0;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          id;
    logic [3:0]  op;
    logic [15:0] a, b, res;
  } vec_t;
  vec_t vt[4];

  // One isolated operation through the main instance, rsp_ready held high.
  task automatic run_op(input vec_t v);
    if (v.id) begin req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
    else      begin req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    #1;
    chk("acc_ready", 32'(v.id ? req1_ready : req0_ready), 1);
    chk("acc_other", 32'(v.id ? req0_ready : req1_ready), 0);
    tick;  // A+1
    req0_valid = 0; req1_valid = 0;
    req0_a = 16'hFFFF; req1_a = 16'hFFFF; req0_b = 16'hFFFF; req1_b = 16'hFFFF;
    #1;
    chk("issue_pulse", 32'(alu_issue), 1);
    chk("issue_op", 32'(alu_op), 32'(v.op));
    chk("issue_a", 32'(alu_a), 32'(v.a));
    chk("issue_b", 32'(alu_b), 32'(v.b));
    for (int i = 0; i < L; i++) begin
      tick;
      chk("wait_no_rsp", 32'({alu_issue, rsp_valid}), 0);
    end
    tick;  // A+L+2
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_result", 32'(rsp_result), 32'(v.res));
    tick;
    chk("back_idle", 32'(busy), 0);
  endtask

  initial begin
    vt[0] = '{id: 1'b0, op: 4'h3, a: 16'h1234, b: 16'h0001, res: 16'h1235};
    vt[1] = '{id: 1'b1, op: 4'h5, a: 16'hFFFF, b: 16'h0001, res: 16'h0000};
    vt[2] = '{id: 1'b0, op: 4'hA, a: 16'h8000, b: 16'h7FFF, res: 16'hFFFF};
    vt[3] = '{id: 1'b1, op: 4'hF, a: 16'h0F0F, b: 16'h1111, res: 16'h2020};

    // Reset with both requesters valid
    req0_valid = 1; req1_valid = 1;
    tick; tick;
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_ctrl", 32'({alu_issue, rsp_valid, busy}), 0);
    chk("rst_data", 32'({alu_op, alu_a, rsp_id}), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_u1_busy", 32'({u1_busy, u1_req1_ready}), 0);
    req0_valid = 0; req1_valid = 0;
    rst = 0;
    tick;

    // Continuous tie: grants alternate 0,1,0,1 and responses follow grants
    begin
      bit gq[$];
      int ng = 0, nrsp = 0;
      req0_a = 16'h0001; req0_b = 16'h0002; req1_a = 16'h0010; req1_b = 16'h0020;
      req0_valid = 1; req1_valid = 1;
      for (int c = 0; c < 60 && nrsp < 4; c++) begin
        #1;
        if (req0_ready && req1_ready) chk("alt_one_ready", 1, 0);
        if (req0_ready || req1_ready) begin
          chk("alt_grant", 32'(req1_ready), 32'(ng % 2));
          gq.push_back(req1_ready);
          ng++;
        end
        if (rsp_valid) begin
          bit eid;
          eid = (gq.size() > 0) ? gq.pop_front() : 1'b0;
          chk("alt_rsp_id", 32'(rsp_id), 32'(eid));
          chk("alt_rsp_res", 32'(rsp_result), eid ? 32'h0030 : 32'h0003);
          nrsp++;
        end
        tick;
        if (ng >= 4) begin req0_valid = 0; req1_valid = 0; end
      end
      chk("alt_rsp_count", 32'(nrsp), 4);
      chk("alt_grant_count", 32'(ng), 4);
    end
    tick; tick;

    // Table of isolated operations
    for (int i = 0; i < 4; i++) run_op(vt[i]);

    // Response back-pressure: rsp_ready low for 5 RESP cycles
    begin
      int c;
      rsp_ready = 0;
      req0_valid = 1; req0_op = 4'h1; req0_a = 16'h0100; req0_b = 16'h0023;
      tick;
      req0_valid = 0;
      for (c = 0; c < 10 && !rsp_valid; c++) tick;
      chk("bp_reach_resp", 32'(rsp_valid), 1);
      req0_valid = 1; req1_valid = 1;
      for (int k = 0; k < 5; k++) begin
        #1;
        chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_result}), {15'd0, 1'b1, 1'b0, 16'h0123});
        chk("bp_no_ready", 32'({req0_ready, req1_ready}), 0);
        tick;
      end
      rsp_ready = 1;
      #1;
      chk("bp_still_valid", 32'(rsp_valid), 1);
      tick;
      chk("bp_ready_back", 32'({req0_ready, req1_ready}), 32'b01);
      req0_valid = 0; req1_valid = 0;
      #1;
      tick;
      chk("bp_drop_no_xfer", 32'(busy), 0);
    end

    // Reset pulse during WAIT
    begin
      int seen = 0;
      req1_valid = 1; req1_op = 4'h7; req1_a = 16'h4444; req1_b = 16'h1111;
      tick;            // ISSUE
      req1_valid = 0;
      tick;            // WAIT
      chk("mid_busy_pre", 32'(busy), 1);
      #2 rst = 1;
      #1;
      chk("mid_busy_async", 32'(busy), 0);
      chk("mid_data_async", 32'({alu_a, rsp_id}), 0);
      tick;
      rst = 0;
      for (int k = 0; k < 8; k++) begin
        tick;
        if (rsp_valid || busy) seen++;
      end
      chk("mid_no_rsp", 32'(seen), 0);
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("mid_tie_req0", 32'({req0_ready, req1_ready}), 32'b10);
      req0_valid = 0; req1_valid = 0;
      tick;
    end

    // ALU_LATENCY = 1 instance, single req1
    u1_req1_valid = 1; u1_req1_op = 4'h2; u1_req1_a = 16'h00AA; u1_req1_b = 16'h0055;
    #1;
    chk("l1_ready", 32'({u1_req0_ready, u1_req1_ready}), 32'b01);
    tick;  // A+1
    u1_req1_valid = 0;
    chk("l1_issue", 32'(u1_alu_issue), 1);
    tick;  // A+2
    chk("l1_wait", 32'({u1_alu_issue, u1_rsp_valid}), 0);
    tick;  // A+3
    chk("l1_rsp_valid", 32'(u1_rsp_valid), 1);
    chk("l1_rsp_id", 32'(u1_rsp_id), 1);
    chk("l1_rsp_result", 32'(u1_rsp_result), 32'h00FF);
    tick;
    chk("l1_idle", 32'(u1_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

endmodule
